// File: rtl/bcd_pkg.sv
// Shared BCD types, limits and helpers for the BCD entry and display paths.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} b2b_state_t;

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One-nibble correction step of reverse double-dabble: subtract 3 from nibbles >= 8.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t adj_c_o
);

  // A nibble >= 8 after the right shift came from an odd tens digit; result stays >= 5.
  assign adj_c_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), valid/ready on both sides.
// Words with any non-decimal nibble are rejected with err instead of being converted.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = 2,
  parameter int unsigned BW   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW-1:0]     bin_out,
  output logic              err
);

  localparam int unsigned DW = 4 * NDIG;
  localparam int unsigned SW = DW + BW;
  localparam int unsigned CW = (BW > 1) ? $clog2(BW) : 1;

  if ((2 ** BW) < (10 ** NDIG)) begin : g_bw_check
    $error("bcd_to_bin_seq: BW too small to hold 10**NDIG-1");
  end

  b2b_state_t     state_q, state_d;
  logic [SW-1:0]  sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bin_q, bin_d;
  logic           err_q, err_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;

  logic [SW-1:0]  sr_shift;
  logic [SW-1:0]  sr_adj;
  logic           in_bad;

  assign sr_shift = sr_q >> 1;

  // Correct every BCD nibble of the shifted word in parallel; binary bits pass through.
  for (genvar g = 0; g < int'(NDIG); g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (sr_shift[BW + 4*g +: 4]),
      .adj_c_o (sr_adj[BW + 4*g +: 4])
    );
  end
  assign sr_adj[BW-1:0] = sr_shift[BW-1:0];

  always_comb begin
    in_bad = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!is_bcd(bcd_in[4*i +: 4])) in_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_bad) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = S_DONE;
          end else begin
            sr_d    = {bcd_in, BW'(0)};
            cnt_d   = CW'(BW - 1);
            err_d   = 1'b0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        sr_d = sr_adj;
        if (cnt_q == '0) begin
          bin_d   = sr_adj[BW-1:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake flags track the state being entered so they stay registered.
    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (NDIG=2, BW=7): vector table, sweep, random, corners.
module tb_bcd_to_bin_seq;

  localparam int unsigned NDIG = 2;
  localparam int unsigned BW   = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [4*NDIG-1:0] bcd_in = '0;
  logic              in_ready;
  logic              out_valid;
  logic [BW-1:0]     bin_out;
  logic              err;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_res = 0;

  bcd_to_bin_seq #(.NDIG(NDIG), .BW(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready)   n_acc <= n_acc + 1;
    if (out_valid && out_ready) n_res <= n_res + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: decimal value of the digits, or error if any digit is not 0..9.
  task automatic model(input logic [7:0] w, output int b, output int e);
    int val, mul, d;
    val = 0; mul = 1; e = 0;
    for (int i = 0; i < int'(NDIG); i++) begin
      d = int'((w >> (4*i)) & 8'h0F);
      if (d > 9) e = 1;
      val += d * mul;
      mul *= 10;
    end
    b = (e != 0) ? 0 : val;
  endtask

  // One transaction; optional output stall and input noise while busy.
  task automatic send(input logic [7:0] w, input int stall, input bit noise,
                      output int b, output int e, output int lat);
    int n;
    bit stable;
    @(negedge clk);
    in_valid = 1'b1; bcd_in = w; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; bcd_in = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (noise) begin in_valid = 1'($urandom); bcd_in = 8'($urandom); end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) check("out_valid_timeout", 0, 1);
    b = int'(bin_out); e = int'(err);
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || int'(bin_out) != b || int'(err) != e || in_ready !== 1'b0)
        stable = 1'b0;
    end
    if (stall > 0) check("stall_stable", int'(stable), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_to_idle", int'({out_valid, in_ready}), 1);
  endtask

  typedef struct {
    logic [7:0] w;
    int         b;
    int         e;
    int         lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int b, e, lat, mb, me, acc0, res0;
    logic [7:0] w;

    tbl[0] = '{8'h42, 42, 0, 8};
    tbl[1] = '{8'h00,  0, 0, 8};
    tbl[2] = '{8'h99, 99, 0, 8};
    tbl[3] = '{8'hA5,  0, 1, 1};
    tbl[4] = '{8'h3F,  0, 1, 1};
    tbl[5] = '{8'h57, 57, 0, 8};
    tbl[6] = '{8'h9A,  0, 1, 1};
    tbl[7] = '{8'h10, 10, 0, 8};

    #2 rst_n = 1'b0;
    #1;
    check("reset_in_ready",  int'(in_ready),  1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_bin_out",   int'(bin_out),   0);
    check("reset_err",       int'(err),       0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].w, 0, 1'b0, b, e, lat);
      check($sformatf("vec%0d_bin", i), b, tbl[i].b);
      check($sformatf("vec%0d_err", i), e, tbl[i].e);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end

    // Every legal two-digit word.
    for (int t = 0; t < 100; t++) begin
      w = {4'(t / 10), 4'(t % 10)};
      send(w, 0, 1'b0, b, e, lat);
      check($sformatf("sweep_%0d", t), b, t);
    end

    // Random words, legal and illegal, with random stalls and busy-time noise.
    for (int t = 0; t < 150; t++) begin
      w = 8'($urandom);
      if ($urandom_range(0, 1) == 0) w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      send(w, int'($urandom_range(0, 3)), 1'($urandom), b, e, lat);
      model(w, mb, me);
      check($sformatf("rand_bin_%02h", w), b, mb);
      check($sformatf("rand_err_%02h", w), e, me);
      check($sformatf("rand_lat_%02h", w), lat, (me != 0) ? 1 : 8);
    end

    // Long back-pressure.
    send(8'h57, 20, 1'b0, b, e, lat);
    check("bp_bin", b, 57);

    // Reset in the middle of a conversion.
    res0 = n_res;
    @(negedge clk);
    in_valid = 1'b1; bcd_in = 8'h88;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready",  int'(in_ready),  1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_bin_out",   int'(bin_out),   0);
    check("abort_err",       int'(err),       0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h12, 0, 1'b0, b, e, lat);
    check("post_abort_bin", b, 12);
    check("post_abort_results", n_res - res0, 1);

    // Noise on the input while busy must not create extra accepts.
    acc0 = n_acc; res0 = n_res;
    for (int t = 0; t < 10; t++) begin
      w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      send(w, int'($urandom_range(0, 2)), 1'b1, b, e, lat);
      model(w, mb, me);
      check($sformatf("busy_bin_%02h", w), b, mb);
    end
    check("busy_accepts", n_acc - acc0, 10);
    check("busy_results", n_res - res0, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
